// File: rtl/rv32i_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding, error codes and default timeout live here.
package rv32i_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } ld_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ZERO = 2'b01;
  localparam logic [1:0] ERR_SIZE = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [15:0] TIMEOUT_DEF = 16'd50000;

endpackage

// File: rtl/byte_packer_rv32i.sv
// Little-endian byte-to-word packer with a 2-bit byte index.
// last_o flags the push that completes a word; word_o is valid then.
module byte_packer_rv32i (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] lo_q, lo_d;

  always_comb begin
    idx_d = idx_q;
    lo_d  = lo_q;
    if (clear_i) begin
      idx_d = 2'd0;
      lo_d  = 24'd0;
    end else if (push_i) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    lo_d[7:0]   = data_i;
        2'd1:    lo_d[15:8]  = data_i;
        2'd2:    lo_d[23:16] = data_i;
        default: lo_d        = lo_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q <= 2'd0;
      lo_q  <= 24'd0;
    end else begin
      idx_q <= idx_d;
      lo_q  <= lo_d;
    end
  end

  assign word_o = {data_i, lo_q};
  assign last_o = push_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader_rv32i.sv
// Streams a length-prefixed byte image into instruction memory
// and holds the CPU in reset until the image is complete.
module imem_loader_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [15:0] TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  ld_state_e   state_q;
  logic [31:0] waddr_q;
  logic [31:0] wdata_q;
  logic [15:0] n_q;
  logic [15:0] cnt_q;
  logic [15:0] idle_q;
  logic [1:0]  err_q;

  logic        idle_st;
  logic        acc;
  logic        tmo;
  logic [15:0] n_full;
  logic        pk_clear;
  logic        pk_push;
  logic        pk_last;
  logic [31:0] pk_word;

  assign idle_st  = (state_q == S_IDLE) || (state_q == S_DONE) ||
                    (state_q == S_ERR);
  assign rx_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                    (state_q == S_DATA);
  assign acc      = rx_valid && rx_ready;
  assign tmo      = (TIMEOUT != 16'd0) && (idle_q == TIMEOUT);
  assign n_full   = {rx_data, n_q[7:0]};
  assign pk_clear = idle_st && start;
  assign pk_push  = acc && (state_q == S_DATA);

  byte_packer_rv32i u_pack (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (pk_clear),
    .push_i  (pk_push),
    .data_i  (rx_data),
    .word_o  (pk_word),
    .last_o  (pk_last)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      waddr_q <= BASE_ADDR;
      wdata_q <= 32'd0;
      n_q     <= 16'd0;
      cnt_q   <= 16'd0;
      idle_q  <= 16'd0;
      err_q   <= ERR_NONE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q <= S_HDR0;
            waddr_q <= BASE_ADDR;
            n_q     <= 16'd0;
            cnt_q   <= 16'd0;
            idle_q  <= 16'd0;
            err_q   <= ERR_NONE;
          end
        end
        S_HDR0: begin
          if (acc) begin
            n_q[7:0] <= rx_data;
            idle_q   <= 16'd0;
            state_q  <= S_HDR1;
          end else if (tmo) begin
            state_q <= S_ERR;
            err_q   <= ERR_TMO;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
        end
        S_HDR1: begin
          if (acc) begin
            n_q[15:8] <= rx_data;
            idle_q    <= 16'd0;
            if (n_full == 16'd0) begin
              state_q <= S_ERR;
              err_q   <= ERR_ZERO;
            end else if ({16'd0, n_full} > DEPTH_U) begin
              state_q <= S_ERR;
              err_q   <= ERR_SIZE;
            end else begin
              state_q <= S_DATA;
            end
          end else if (tmo) begin
            state_q <= S_ERR;
            err_q   <= ERR_TMO;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
        end
        S_DATA: begin
          if (acc) begin
            idle_q <= 16'd0;
            if (pk_last) begin
              wdata_q <= pk_word;
              state_q <= S_WRITE;
            end
          end else if (tmo) begin
            state_q <= S_ERR;
            err_q   <= ERR_TMO;
          end else begin
            idle_q <= idle_q + 16'd1;
          end
        end
        S_WRITE: begin
          waddr_q <= waddr_q + 32'd4;
          cnt_q   <= cnt_q + 16'd1;
          if (cnt_q + 16'd1 == n_q) state_q <= S_DONE;
          else                      state_q <= S_DATA;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = (state_q == S_WRITE);
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = rx_ready || imem_we;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign cpu_hold   = (state_q != S_DONE);
  assign err_code   = err_q;

endmodule

// File: tb/tb_imem_loader_rv32i.sv
// Randomized scoreboard bench for imem_loader_rv32i.
// Stimulus pushes expected writes/outcomes; a monitor pops and compares.
module tb_imem_loader_rv32i;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 4;
  localparam logic [15:0] TMO   = 16'd8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  imem_loader_rv32i #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .TIMEOUT     (TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] waddr;
  } end_t;

  wr_t  wr_q[$];
  end_t end_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_end = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    wr_t  w;
    end_t e;
    if (reset) begin
      chk("hold_vs_done", {31'd0, cpu_hold}, {31'd0, !done});
      if (imem_we) begin
        chk("ready_in_write", {31'd0, rx_ready}, 32'd0);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h:%h expected=none",
                   imem_waddr, imem_wdata);
        end else begin
          w = wr_q.pop_front();
          chk("waddr", imem_waddr, w.addr);
          chk("wdata", imem_wdata, w.data);
        end
      end
      if ((done || error) && !prev_end) begin
        if (end_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end actual=%b%b expected=none",
                   done, error);
        end else begin
          e = end_q.pop_front();
          chk("end_done", {31'd0, done}, {31'd0, e.code == 2'b00});
          chk("end_error", {31'd0, error}, {31'd0, e.code != 2'b00});
          chk("end_code", {30'd0, err_code}, {30'd0, e.code});
          chk("end_waddr", imem_waddr, e.waddr);
        end
      end
    end
    prev_end = done || error;
  end

  // Reference: a load of n words either fails outright or writes every word.
  task automatic expect_load(int n, logic [7:0] d[$]);
    if (n == 0) begin
      end_q.push_back('{2'b01, BASE});
    end else if (n > DEPTH) begin
      end_q.push_back('{2'b10, BASE});
    end else begin
      for (int i = 0; i < n; i++)
        wr_q.push_back('{BASE + 32'(4 * i),
                         {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]}});
      end_q.push_back('{2'b00, BASE + 32'(4 * n)});
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int maxgap);
    int gap;
    gap = int'($urandom_range(maxgap, 0));
    repeat (gap) begin
      @(negedge clock);
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_data = b;
      if (rx_ready) begin
        @(posedge clock);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL byte_accept actual=stalled expected=accepted");
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    @(negedge clock);
    rx_valid = 1'b0;
    for (t = 0; t < 100; t++) begin
      if (done || error) break;
      @(negedge clock);
    end
    if (t == 100) begin
      checks++;
      errors++;
      $display("FAIL load_end actual=none expected=done_or_error");
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic do_load(int n, int maxgap, int poke);
    logic [7:0]  d[$];
    logic [15:0] nn;
    int          nb;
    nn = 16'(n);
    nb = (n >= 1 && n <= DEPTH) ? 4 * n : 0;
    for (int i = 0; i < nb; i++) d.push_back(8'($urandom));
    expect_load(n, d);
    pulse_start();
    send_byte(nn[7:0], maxgap);
    send_byte(nn[15:8], maxgap);
    for (int i = 0; i < nb; i++) begin
      if (i == poke) begin
        pulse_start();
        chk("busy_start_ignored", {31'd0, busy}, 32'd1);
        chk("ready_start_ignored", {31'd0, rx_ready}, 32'd1);
      end
      send_byte(d[i], maxgap);
    end
    wait_end();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] d[$];
    int         edges;

    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_waddr", imem_waddr, BASE);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    d = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    expect_load(2, d);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    foreach (d[i]) send_byte(d[i], 1);
    wait_end();
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_hold", {31'd0, cpu_hold}, 32'd0);

    do_load(0, 1, -1);
    chk("zero_hold", {31'd0, cpu_hold}, 32'd1);
    do_load(5, 1, -1);
    chk("size_busy", {31'd0, busy}, 32'd0);

    end_q.push_back('{2'b11, BASE});
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    #1 rx_valid = 1'b0;
    for (edges = 1; edges < 20; edges++) begin
      @(posedge clock);
      #1;
      if (error) break;
    end
    chk("timeout_edges", edges, 32'd9);
    repeat (2) @(negedge clock);

    do_load(2, 0, -1);

    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_load(1, d);
    end_q.delete();
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    foreach (d[i]) send_byte(d[i], 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data = 8'h04;
    reset = 1'b0;
    @(negedge clock);
    rx_valid = 1'b0;
    chk("abort_we", {31'd0, imem_we}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_waddr", imem_waddr, BASE);
    chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
    reset = 1'b1;
    @(negedge clock);

    do_load(3, 1, 5);

    for (int k = 0; k < 10; k++)
      do_load(int'($urandom_range(5, 0)), 3,
              ($urandom_range(3, 0) == 0) ? 2 : -1);

    chk("writes_left", wr_q.size(), 32'd0);
    chk("ends_left", end_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader_rv32i.md
IMEM_LOADER_RV32I -- requirements
Module: imem_loader_rv32i

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word (word-aligned).
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, maximum loadable word count.
REQ-003 SHALL have parameter TIMEOUT, default 16'd50000, maximum idle cycles between accepted bytes; 0 disables the timeout.
REQ-004 clock  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a load.
REQ-007 rx_valid  in  1  byte-stream valid.
REQ-008 rx_data  in  8  byte-stream data.
REQ-009 rx_ready  out  1  loader can accept a byte.
REQ-010 imem_we  out  1  instruction-memory write strobe.
REQ-011 imem_waddr  out  32  instruction-memory byte address.
REQ-012 imem_wdata  out  32  instruction-memory write word.
REQ-013 cpu_hold  out  1  active-high hold for the CPU core reset.
REQ-014 busy / done / error  out  1 each  status flags.
REQ-015 err_code  out  2  01 zero length, 10 oversize, 11 timeout, 00 none.

Function
REQ-016 SHALL implement states IDLE, HDR0, HDR1, DATA, WRITE, DONE and ERR.
REQ-017 start SHALL be honoured only in IDLE, DONE and ERR (-> HDR0: clear done/error/err_code, waddr=BASE_ADDR, byte index 0); start in any other state SHALL be ignored.
REQ-018 A byte SHALL be accepted only when rx_valid && rx_ready; rx_ready=1 exactly in HDR0, HDR1 and DATA.
REQ-019 HDR0 SHALL latch N[7:0] and HDR1 SHALL latch N[15:8] (little-endian word count).
REQ-020 On leaving HDR1, N==0 SHALL go to ERR with err_code 01, and N>DEPTH_WORDS SHALL go to ERR with err_code 10; otherwise it SHALL go to DATA.
REQ-021 DATA SHALL pack bytes little-endian (first byte -> bits[7:0]); acceptance of the 4th byte in cycle k SHALL give WRITE in cycle k+1.
REQ-022 In WRITE, imem_we SHALL be 1 for exactly one cycle, with imem_wdata={b3,b2,b1,b0} and the current imem_waddr.
REQ-023 On the cycle after WRITE, imem_waddr SHALL increment by 4 (32-bit wrap) and the word count SHALL increment.
REQ-024 After WRITE, the state SHALL go to DONE if words written == N, else back to DATA.
REQ-025 Throughput SHALL be at most 4 bytes per 5 cycles because of the WRITE bubble.
REQ-026 The idle counter SHALL clear on entry to HDR0 and on every accepted byte, and count in HDR0/HDR1/DATA.
REQ-027 When the idle counter reaches TIMEOUT (TIMEOUT != 0), the state SHALL go to ERR with err_code 11 on the next cycle.
REQ-028 A partial word SHALL never be written.
REQ-029 busy SHALL be 1 in HDR0, HDR1, DATA and WRITE.
REQ-030 done SHALL be 1 only in DONE and error SHALL be 1 only in ERR.
REQ-031 cpu_hold SHALL be 0 only in DONE; 1 in every other state, including ERR and after a reload start.
REQ-032 imem_we SHALL be 0 in every state except WRITE.
REQ-033 rx_data SHALL be ignored when rx_valid=0.

Reset
REQ-034 When reset=0 at a clock edge, the block SHALL go to IDLE with rx_ready=0, imem_we=0, imem_waddr=BASE_ADDR, imem_wdata=0, cpu_hold=1, busy=0, done=0, error=0, err_code=00, and all counters zero.
REQ-035 Reset mid-load SHALL abort immediately without a write strobe in the following cycle; already-written words are not retracted.
REQ-036 reset SHALL take priority over start.

Structure
REQ-037 The state encoding, err_code values and the default TIMEOUT SHALL live in the shared package rv32i_pkg.
REQ-038 Byte packing and its 2-bit byte index SHALL be a sub-module byte_packer_rv32i; the FSM, counters and timeout remain in imem_loader_rv32i.

Verification
REQ-039 Basic load: start, bytes 02 00 13 00 50 00 93 00 10 00 -> imem_we at 0x0 with 0x00500013, then at 0x4 with 0x00100093; done=1, cpu_hold=0.
REQ-040 Zero length: bytes 00 00 -> ERR, err_code=01, no imem_we, cpu_hold=1.
REQ-041 Oversize with DEPTH_WORDS=4: bytes 05 00 -> ERR, err_code=10.
REQ-042 Timeout with TIMEOUT=8: send header 01 00 plus 2 data bytes, then hold rx_valid=0 -> ERR 9 cycles after the last byte, err_code=11, no write.
REQ-043 Backpressure: rx_valid held high continuously with N=2 -> rx_ready=0 in each WRITE cycle, no byte lost, exactly 2 strobes.
REQ-044 Reset mid-DATA followed by a new start -> restart at BASE_ADDR; ignored start while busy -> no state change.
